// File: rtl/rest_div8b4_if.sv
// Handshake and data bundle for the 8/4 restoring divider.
// Master drives the request; slave returns result and status.
interface rest_div8b4_if;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic [7:0] quo;
  logic [3:0] rem;
  logic       busy;
  logic       done;
  logic       dbz;

  modport master (
    output start, dividend, divisor,
    input  quo, rem, busy, done, dbz
  );

  modport slave (
    input  start, dividend, divisor,
    output quo, rem, busy, done, dbz
  );
endinterface

// File: rtl/rest_div8b4.sv
// Unsigned 8-by-4 restoring divider, one quotient bit per cycle.
// Divide-by-zero skips iteration and reports quo=FF, rem=0, dbz=1.
module rest_div8b4 (
  input logic          clk,
  input logic          rst,
  rest_div8b4_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] dvd_q, dvd_d;
  logic [3:0] dvs_q, dvs_d;
  logic [4:0] prem_q, prem_d;
  logic [7:0] qacc_q, qacc_d;
  logic [7:0] quo_q, quo_d;
  logic [3:0] rem_q, rem_d;
  logic       dbz_q, dbz_d;

  logic [5:0] sh;
  logic [5:0] diff;
  logic       ge;
  logic [4:0] np;
  logic       unused_bits;

  // partial remainder stays below the divisor, so bit 5 is always 0
  always_comb begin
    sh   = {prem_q, dvd_q[7]};
    diff = sh - {2'b00, dvs_q};
    ge   = (sh >= {2'b00, dvs_q});
    np   = ge ? diff[4:0] : sh[4:0];
  end

  assign unused_bits = ^{sh[5], diff[5]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    prem_d  = prem_q;
    qacc_d  = qacc_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          dvd_d  = bus.dividend;
          dvs_d  = bus.divisor;
          dbz_d  = 1'b0;
          cnt_d  = 3'd0;
          prem_d = 5'd0;
          qacc_d = 8'd0;
          if (bus.divisor == 4'd0) begin
            quo_d   = 8'hFF;
            rem_d   = 4'h0;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        prem_d = np;
        qacc_d = {qacc_q[6:0], ge};
        dvd_d  = {dvd_q[6:0], 1'b0};
        cnt_d  = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          quo_d   = {qacc_q[6:0], ge};
          rem_d   = np[3:0];
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      dvd_q   <= 8'd0;
      dvs_q   <= 4'd0;
      prem_q  <= 5'd0;
      qacc_q  <= 8'd0;
      quo_q   <= 8'd0;
      rem_q   <= 4'd0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      prem_q  <= prem_d;
      qacc_q  <= qacc_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.quo  = quo_q;
  assign bus.rem  = rem_q;
  assign bus.dbz  = dbz_q;
  assign bus.busy = (state_q == CALC);
  assign bus.done = (state_q == DONE);

endmodule

// File: tb/tb_rest_div8b4.sv
// Bench for rest_div8b4: directed cases, random operands with
// mid-flight noise, and an exhaustive sweep against a / and % model.
module tb_rest_div8b4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  rest_div8b4_if bus ();

  rest_div8b4 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errs = 0;
  int nchk = 0;
  logic [7:0] pq;
  logic [3:0] pr;
  int lat, bc, dn;
  int pos[$];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // call at a negedge; returns at the negedge after the done cycle
  task automatic run(input logic [7:0] a,
                     input logic [3:0] b,
                     input bit noise,
                     output int lt,
                     output int bcnt);
    logic [7:0] eq;
    logic [3:0] er;
    logic       ez;
    bit         held;
    int         n;
    if (b == 4'd0) begin
      eq = 8'hFF; er = 4'h0; ez = 1'b1;
    end else begin
      eq = a / b; er = 4'(a % b); ez = 1'b0;
    end
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    held = 1'b1;
    n    = 0;
    bcnt = 0;
    lt   = -1;
    while (n < 20 && lt < 0) begin
      @(negedge clk);
      n++;
      if (bus.done) begin
        lt = n;
      end else begin
        if (bus.busy) bcnt++;
        if (bus.quo !== pq || bus.rem !== pr || bus.dbz !== 1'b0)
          held = 1'b0;
        if (noise) begin
          bus.start    = 1'($urandom_range(0, 1));
          bus.dividend = 8'($urandom);
          bus.divisor  = 4'($urandom);
        end
      end
    end
    bus.start = 1'b0;
    chk("hold", 32'(held), 32'd1);
    chk("result", 32'({bus.quo, bus.rem, bus.dbz}), 32'({eq, er, ez}));
    @(negedge clk);
    chk("done_1cyc", 32'({bus.done, bus.busy}), 32'd0);
    pq = eq;
    pr = er;
  endtask

  task automatic run_chk(input logic [7:0] a,
                         input logic [3:0] b,
                         input bit noise);
    int l, c;
    run(a, b, noise, l, c);
    chk("latency", 32'(l), (b == 4'd0) ? 32'd1 : 32'd9);
    chk("busy_cyc", 32'(c), (b == 4'd0) ? 32'd0 : 32'd8);
  endtask

  initial begin
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = 8'd0;
    bus.divisor  = 4'd0;
    pq = 8'd0;
    pr = 4'd0;
    repeat (3) @(negedge clk);
    chk("rst_out", 32'({bus.quo, bus.rem, bus.busy, bus.done, bus.dbz}), 32'd0);
    rst = 1'b0;

    run(8'd200, 4'd7, 1'b0, lat, bc);
    chk("lat_200_7", 32'(lat), 32'd9);
    chk("busy_200_7", 32'(bc), 32'd8);
    run_chk(8'd255, 4'd15, 1'b0);
    run_chk(8'd5, 4'd13, 1'b0);
    run(8'd100, 4'd0, 1'b0, lat, bc);
    chk("lat_dbz", 32'(lat), 32'd1);
    chk("busy_dbz", 32'(bc), 32'd0);
    run_chk(8'd100, 4'd10, 1'b0);

    // start during the 4th CALC cycle must be dropped
    bus.start    = 1'b1;
    bus.dividend = 8'd200;
    bus.divisor  = 4'd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    dn = 0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (i == 9) chk("ign_done", 32'(bus.done), 32'd1);
      else dn += int'(bus.done);
      if (i == 4) begin
        bus.start    = 1'b1;
        bus.dividend = 8'd9;
        bus.divisor  = 4'd3;
      end
      if (i == 5) bus.start = 1'b0;
    end
    chk("ign_res", 32'({bus.quo, bus.rem}), 32'({8'd28, 4'd4}));
    repeat (12) begin
      @(negedge clk);
      dn += int'(bus.done);
    end
    chk("ign_nodup", 32'(dn), 32'd0);
    pq = 8'd28;
    pr = 4'd4;

    // reset in the 4th CALC cycle aborts silently
    bus.start    = 1'b1;
    bus.dividend = 8'd200;
    bus.divisor  = 4'd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid", 32'({bus.quo, bus.rem, bus.busy, bus.done, bus.dbz}), 32'd0);
    dn = 0;
    repeat (12) begin
      @(negedge clk);
      dn += int'(bus.done);
    end
    chk("rst_nodone", 32'(dn), 32'd0);
    pq = 8'd0;
    pr = 4'd0;
    run_chk(8'd144, 4'd12, 1'b0);

    // start held high: one result every 10 cycles
    bus.start    = 1'b1;
    bus.dividend = 8'd200;
    bus.divisor  = 4'd7;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (bus.done) begin
        pos.push_back(i);
        chk("cont_res", 32'({bus.quo, bus.rem}), 32'({8'd28, 4'd4}));
      end
      if (i == 29) bus.start = 1'b0;
    end
    chk("cont_n", 32'(pos.size()), 32'd3);
    if (pos.size() == 3)
      chk("cont_pos", 32'({8'(pos[0]), 8'(pos[1]), 8'(pos[2])}),
          32'({8'd9, 8'd19, 8'd29}));
    pq = 8'd28;
    pr = 4'd4;

    repeat (300) begin
      logic [7:0] a;
      logic [3:0] b;
      a = 8'($urandom);
      b = ($urandom_range(0, 9) == 0) ? 4'd0 : 4'($urandom);
      run_chk(a, b, 1'b1);
    end

    for (int a = 0; a < 256; a++)
      for (int b = 0; b < 16; b++)
        run_chk(8'(a), 4'(b), 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule

// File: doc/rest_div8b4.md
REST_DIV8B4 -- requirements
Module: rest_div8b4

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of clk.
REQ-002 The block SHALL have these ports:
- clk, input, 1 bit: rising-edge clock.
- rst, input, 1 bit: synchronous reset, active-high.
- start, input, 1 bit: request to begin a division.
- dividend, input, 8 bits: unsigned dividend (the full product width of the 4x4 multiplier).
- divisor, input, 4 bits: unsigned divisor.
- quo, output, 8 bits: registered quotient.
- rem, output, 4 bits: registered remainder.
- busy, output, 1 bit: high while a division is in progress.
- done, output, 1 bit: one-cycle pulse when a result is valid.
- dbz, output, 1 bit: divide-by-zero flag for the latest result.
REQ-003 The block SHALL have no parameters; all widths are fixed as listed.

Function
REQ-004 The block SHALL implement a three-state FSM: IDLE, CALC and DONE.
REQ-005 In IDLE, start=1 at a rising edge SHALL accept the request:
- dividend and divisor are latched into internal registers.
- dbz is cleared.
- The 3-bit iteration counter is set to 0.
REQ-006 On an accepted start with divisor != 0, the FSM SHALL enter CALC and busy SHALL be 1 from the next cycle.
REQ-007 On an accepted start with divisor == 0, the FSM SHALL go directly to DONE with quo=8'hFF, rem=4'h0 and dbz=1, and SHALL NOT enter CALC.
REQ-008 Each CALC cycle SHALL perform one restoring iteration, MSB first:
- Shift the 5-bit partial remainder left and bring in the next dividend bit.
- Subtract the zero-extended divisor.
- If the result is non-negative, keep the difference and shift in quotient bit 1.
- Otherwise, restore the partial remainder and shift in quotient bit 0.
REQ-009 CALC SHALL last exactly 8 cycles; on the 8th iteration edge the FSM SHALL enter DONE and load quo and rem with the final values.
REQ-010 Latency SHALL be fixed:
- Accept on edge k: done=1 in the cycle after edge k+8.
- Divide-by-zero: done=1 in the cycle after edge k.
REQ-011 done SHALL be high for exactly one cycle, in DONE only; the FSM SHALL return to IDLE on the following edge.
REQ-012 busy SHALL be 1 only in CALC and 0 in IDLE and DONE.
REQ-013 quo, rem and dbz SHALL hold their last values until the next result is loaded; they SHALL NOT change during CALC, and dbz is the only one cleared at accept.
REQ-014 start SHALL be ignored in CALC and DONE; ignored requests SHALL NOT be queued, and dividend/divisor changes in those states SHALL NOT affect the result in progress.
REQ-015 start held high continuously SHALL restart a division on every IDLE visit, giving one result every 10 cycles.
REQ-016 For divisor != 0, results SHALL satisfy dividend == quo*divisor + rem with rem < divisor, for all 8-bit dividends and 4-bit divisors.
REQ-017 Quotient bits SHALL be computed at full 8-bit width; no internal overflow is permitted, since partial remainder < 2*divisor <= 30 fits in 5 bits.

Reset
REQ-018 rst=1 at a rising edge SHALL force:
- FSM to IDLE and counter to 0.
- quo=0, rem=0, busy=0, done=0, dbz=0.
REQ-019 rst SHALL take priority over start and over any in-progress CALC or DONE; an aborted division SHALL produce no done pulse.
REQ-020 The first cycle after rst deasserts SHALL be IDLE, able to accept start.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Normal division: dividend=200, divisor=7, start pulse -> busy for 8 cycles, then done pulse with quo=28, rem=4, dbz=0, 9 cycles after accept.
- Maximum operands: dividend=255, divisor=15 -> quo=17, rem=0; then dividend=5, divisor=13 -> quo=0, rem=5.
- Divide by zero: dividend=100, divisor=0 -> done in the cycle after accept, quo=8'hFF, rem=0, dbz=1, busy never asserted; a following 100/10 -> quo=10, rem=0, dbz=0.
- Ignored start: start pulsed with 9/3 during the 4th CALC cycle of 200/7 -> result stays 28/4; no second done pulse.
- Reset mid-operation: rst at the 4th CALC cycle of 200/7 -> next cycle all outputs 0, no done pulse; a subsequent 144/12 -> quo=12, rem=0.
- Exhaustive self-check: all 4096 dividend/divisor pairs -> REQ-016 holds for every divisor != 0, and REQ-007 holds for every divisor == 0.
